// File: rtl/pot_write_scheduler.sv
// Arbitrates two coalescing write slots onto the single digital-pot I2C write master.
// Define POT_REFRESH_EN to periodically rewrite last_value when no request is pending.
module pot_write_scheduler #(
  parameter int unsigned MAX_VALUE      = 100,
  parameter int unsigned START_TIMEOUT  = 64,
  parameter int unsigned GAP_CYCLES     = 160,
  parameter int unsigned REFRESH_PERIOD = 1600000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       i2c_ready,
  output logic       i2c_enable,
  output logic [7:0] i2c_data,
  output logic       busy,
  output logic [1:0] grant,
  output logic       done,
  output logic [7:0] last_value,
  output logic       timeout_err,
  output logic       refresh
);

  localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t           state_r;
  logic             slot0_valid_r;
  logic             slot1_valid_r;
  logic [7:0]       slot0_data_r;
  logic [7:0]       slot1_data_r;
  logic             rr_ptr_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             take0_s;
  logic             take1_s;
  logic             ref_go_s;
  logic             start_s;
  logic             to_last_s;
  logic             gap_last_s;

  function automatic logic [7:0] clamp_value(input logic [7:0] v);
    return (32'(v) > MAX_VALUE) ? 8'(MAX_VALUE) : v;
  endfunction

  assign to_last_s  = (to_cnt_r == TO_W'(START_TIMEOUT - 32'd1));
  assign gap_last_s = (GAP_CYCLES <= 32'd1) || (gap_cnt_r == GAP_W'(GAP_CYCLES - 32'd1));

  // Round-robin pick in IDLE; rr_ptr_r=1 means req1 has priority on a tie.
  always_comb begin
    take0_s = 1'b0;
    take1_s = 1'b0;
    if (state_r == S_IDLE && i2c_ready == 1'b1) begin
      if (slot0_valid_r && (!slot1_valid_r || !rr_ptr_r)) begin
        take0_s = 1'b1;
      end else if (slot1_valid_r) begin
        take1_s = 1'b1;
      end else begin
        take1_s = 1'b0;
      end
    end else begin
      take0_s = 1'b0;
    end
  end

`ifdef POT_REFRESH_EN
  localparam int REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD + 1) : 1;
  logic [REF_W-1:0] ref_cnt_r;
  logic             ref_full_s;

  assign ref_full_s = (ref_cnt_r == REF_W'(REFRESH_PERIOD - 32'd1));
  assign ref_go_s   = (state_r == S_IDLE) && i2c_ready && !slot0_valid_r &&
                      !slot1_valid_r && ref_full_s;
`else
  assign ref_go_s = 1'b0;
  assign refresh  = 1'b0;
`endif

  assign start_s = take0_s | take1_s | ref_go_s;

  // Slots, arbitration pointer, transaction sequencer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      slot0_valid_r <= 1'b0;
      slot1_valid_r <= 1'b0;
      slot0_data_r  <= 8'd0;
      slot1_data_r  <= 8'd0;
      rr_ptr_r      <= 1'b0;
      to_cnt_r      <= '0;
      gap_cnt_r     <= '0;
      i2c_enable    <= 1'b0;
      i2c_data      <= 8'd0;
      busy          <= 1'b0;
      grant         <= 2'b00;
      done          <= 1'b0;
      last_value    <= 8'd0;
      timeout_err   <= 1'b0;
`ifdef POT_REFRESH_EN
      ref_cnt_r     <= '0;
      refresh       <= 1'b0;
`endif
    end else begin
      i2c_enable <= 1'b0;
      grant      <= 2'b00;
      done       <= 1'b0;
`ifdef POT_REFRESH_EN
      refresh    <= 1'b0;
`endif
      // A request in the same cycle as the clear wins (ordering of the writes below).
      if (take0_s) slot0_valid_r <= 1'b0;
      if (take1_s) slot1_valid_r <= 1'b0;
      if (req0_valid) begin
        slot0_valid_r <= 1'b1;
        slot0_data_r  <= clamp_value(req0_data);
      end
      if (req1_valid) begin
        slot1_valid_r <= 1'b1;
        slot1_data_r  <= clamp_value(req1_data);
      end

      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r    <= S_ISSUE;
            busy       <= 1'b1;
            i2c_enable <= 1'b1;
            grant      <= {take1_s, take0_s};
            i2c_data   <= take0_s ? slot0_data_r : (take1_s ? slot1_data_r : last_value);
            if (take0_s || take1_s) rr_ptr_r <= take0_s;
`ifdef POT_REFRESH_EN
            refresh    <= ref_go_s;
            ref_cnt_r  <= '0;
          end else if (!ref_full_s) begin
            ref_cnt_r  <= ref_cnt_r + REF_W'(1);
`endif
          end
        end
        S_ISSUE: begin
          state_r  <= S_WAIT_BUSY;
          to_cnt_r <= '0;
        end
        S_WAIT_BUSY: begin
          if (!i2c_ready) begin
            state_r <= S_WAIT_DONE;
          end else if (to_last_s) begin
            timeout_err <= 1'b1;
            state_r     <= S_GAP;
            gap_cnt_r   <= '0;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (i2c_ready) begin
            last_value <= i2c_data;
            done       <= 1'b1;
            state_r    <= S_GAP;
            gap_cnt_r  <= '0;
          end
        end
        S_GAP: begin
          if (gap_last_s) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
